cpu_mem_bridge: RTL and testbench
=================================

# cpu_mem_bridge

Bridges the 6502 core's bus requests onto the memory controller's single-request port. Captures one CPU access at a time and holds it until the controller is free. Issues a one-cycle read or write enable, then stalls the core with `cpu_rdy` until the controller completes. Returns read data to the core and flags a controller that stays busy too long.

## Interface
- `TIMEOUT`, default 1024: WAIT-state cycles allowed before a fatal error; legal range 2..65535.
- `clk`  in  1  single clock for the block.
- `reset`  in  1  **synchronous, active-low** reset, sampled on `posedge clk`.
- `cpu_req`  in  1  core requests an access; sampled only while `cpu_rdy`=1.
- `cpu_rw`  in  1  1 = read, 0 = write.
- `cpu_addr`  in  16  access address.
- `cpu_dout`  in  8  write data from the core.
- `cpu_rdy`  out  1  1 = bridge idle and accepting requests; 0 = stall the core.
- `cpu_din`  out  8  read data to the core; valid from the cycle `cpu_rdy` returns high after a read.
- `mem_addr`  out  16  address to the controller.
- `mem_wdata`  out  8  write data to the controller.
- `mem_read_en`  out  1  one-cycle read strobe.
- `mem_write_en`  out  1  one-cycle write strobe.
- `mem_busy`  in  1  controller busy; also high during the controller's reset/BIST.
- `mem_rdata`  in  8  controller read data; valid in the first cycle `mem_busy` is low after a read.
- `mem_err`  out  1  sticky timeout error.

## Operation
- **Controller contract**
  - A strobe is legal only while `mem_busy`=0.
  - `mem_busy` rises the cycle after the strobe and stays high for at least 1 cycle.
- **States:** IDLE, ISSUE, WAIT, ERROR. `cpu_rdy` = (state==IDLE).
- **IDLE**
  - On `cpu_req`=1: latch `cpu_addr`→`mem_addr`, `cpu_dout`→`mem_wdata`, and `cpu_rw` internally; go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - If `mem_busy`=1: hold with both strobes low. There is no timeout here, so controller BIST may run indefinitely.
  - If `mem_busy`=0: assert `mem_read_en` (read) or `mem_write_en` (write) for this cycle only; clear the timeout counter; go to WAIT.
- **WAIT**
  - First cycle: `mem_busy` is ignored, because it lags the strobe by one cycle.
  - Afterwards, `mem_busy`=0 completes the access. On a read, register `mem_rdata`→`cpu_din`. Go to IDLE.
  - Counter increments each WAIT cycle. At count==TIMEOUT−1 with `mem_busy` still 1, go to ERROR.
- **ERROR**
  - Terminal until reset.
  - `mem_err`=1, `cpu_rdy`=0, strobes low.
- `cpu_din` holds its last read value across writes and idle cycles. Writes never modify it.
- Latched `mem_addr`/`mem_wdata` stay stable from ISSUE entry until the next accepted request.
- **Reset**
  - Values: state IDLE, `cpu_rdy`=1, `cpu_din`=8'h00, `mem_addr`=16'h0000, `mem_wdata`=8'h00, both strobes 0, `mem_err`=0, counter 0.
  - Reset mid-access abandons the access with no strobe. Any strobe already issued is not retracted.

## Timing
- Request accepted at cycle 0 (IDLE, `cpu_rdy`=1); `cpu_rdy`=0 from cycle 1.
- With `mem_busy` low at cycle 1, the strobe occurs at cycle 1.
- With busy high cycles 2..N+1, completion is seen at cycle N+2 and `cpu_rdy`=1 at N+3.
- **Read latency:** strobe-to-ready = N+2 cycles; request-to-ready = N+3.
- At most one strobe per access; never both strobes in one cycle.
- Busy falls in the same cycle the counter hits TIMEOUT−1: completion wins, no error.
- `cpu_req` while `cpu_rdy`=0 is ignored; the core must hold it until accepted.

## Structure
- **Shared package `mem_bus_pkg`**
  - One-hot state indices (IDLE/ISSUE/WAIT/ERROR).
  - Read/write encoding constants.
  - Reset values for the address and data buses.
  - Shared with the memory controller.
- **Sub-module `timeout_cnt`**
  - Parameterised saturating counter: clear, enable, terminal-count flag.
  - Width = $clog2(TIMEOUT).

## Test plan
- **Read with busy during BIST:** hold `mem_busy`=1 for 40 cycles after reset, then request read @16'h1234. Expect no strobe until busy drops, then one `mem_read_en` pulse with `mem_addr`=16'h1234.
- **Read data return:** controller returns 8'hA5 after N=3 busy cycles. Expect `cpu_rdy`=1 exactly 6 cycles after acceptance, `cpu_din`=8'hA5.
- **Write, then idle:** write 8'h55 @16'hFFFC, busy 2 cycles. Expect one `mem_write_en` pulse with `mem_wdata`=8'h55; `cpu_din` unchanged from the previous read.
- **Timeout:** TIMEOUT=8, busy stuck high after strobe. Expect `mem_err`=1 and `cpu_rdy`=0 permanently; a `cpu_req` pulse produces no strobe. Reset restores `cpu_rdy`=1 and `mem_err`=0.
- **Completion at limit:** TIMEOUT=8, busy falls exactly in the last counted WAIT cycle. Expect normal completion and `mem_err`=0.
- **Mid-access reset:** assert `reset`=0 during ISSUE with busy high. Expect all outputs at reset values next cycle and no strobe issued.

Source files
------------

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_pkg
// Brief  : Shared CPU/memory bus encodings (state, R/W, reset values).
// Rev    : 1.0
// ============================================================================
package mem_bus_pkg;

    localparam int c_IDX_IDLE  = 0;
    localparam int c_IDX_ISSUE = 1;
    localparam int c_IDX_WAIT  = 2;
    localparam int c_IDX_ERROR = 3;
    localparam int c_STATE_W   = 4;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 4'(1 << c_IDX_IDLE),
        ST_ISSUE = 4'(1 << c_IDX_ISSUE),
        ST_WAIT  = 4'(1 << c_IDX_WAIT),
        ST_ERROR = 4'(1 << c_IDX_ERROR)
    } bus_state_t;

    localparam logic c_RW_READ  = 1'b1;
    localparam logic c_RW_WRITE = 1'b0;

    localparam int          c_ADDR_W   = 16;
    localparam int          c_DATA_W   = 8;
    localparam logic [15:0] c_ADDR_RST = 16'h0000;
    localparam logic [7:0]  c_DATA_RST = 8'h00;

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module : timeout_cnt
// Brief  : Saturating up-counter with clear, enable and terminal-count flag.
// Rev    : 1.0
// ============================================================================
module timeout_cnt #(
    parameter int LIMIT = 1024,
    parameter int WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_TERMINAL = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_TERMINAL)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
    assign tc    = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : cpu_mem_bridge
// Brief  : Single-outstanding bridge from 6502 bus to memory controller port.
// Rev    : 1.0
// ============================================================================
module cpu_mem_bridge
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_din,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic        mem_busy,
    input  logic [7:0]  mem_rdata,
    output logic        mem_err
);

    localparam int c_CNT_W = cnt_width(TIMEOUT);

    bus_state_t          r_state;
    logic                r_rw;
    logic [15:0]         r_addr;
    logic [7:0]          r_wdata;
    logic [7:0]          r_din;

    logic                w_issue_go;
    logic                w_in_wait;
    logic                w_first_wait;
    logic                w_tc;
    logic [c_CNT_W-1:0]  w_count;

    // Strobe depends on this cycle's busy, so it cannot be registered.
    // Gating with reset keeps an abandoned access from strobing.
    assign w_issue_go   = (r_state == ST_ISSUE) && !mem_busy && reset;
    assign w_in_wait    = (r_state == ST_WAIT);
    // Counter is cleared on the strobe and saturates at TIMEOUT-1 >= 1,
    // so zero only occurs in the first WAIT cycle.
    assign w_first_wait = (w_count == '0);

    timeout_cnt #(
        .LIMIT (TIMEOUT),
        .WIDTH (c_CNT_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_issue_go),
        .en    (w_in_wait),
        .count (w_count),
        .tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_rw    <= c_RW_READ;
            r_addr  <= c_ADDR_RST;
            r_wdata <= c_DATA_RST;
            r_din   <= c_DATA_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_rw    <= cpu_rw;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_dout;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_busy) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Completion has priority over the timeout at the limit.
                    if (!w_first_wait && !mem_busy) begin
                        if (r_rw == c_RW_READ) begin
                            r_din <= mem_rdata;
                        end
                        r_state <= ST_IDLE;
                    end else if (!w_first_wait && w_tc) begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    assign cpu_rdy      = r_state[c_IDX_IDLE];
    assign mem_err      = r_state[c_IDX_ERROR];
    assign cpu_din      = r_din;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_read_en  = w_issue_go && (r_rw == c_RW_READ);
    assign mem_write_en = w_issue_go && (r_rw == c_RW_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_mem_bridge
// Brief  : Scoreboard bench for cpu_mem_bridge with a scripted controller.
// Rev    : 1.0
// ============================================================================
module tb_cpu_mem_bridge;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_rdy;
    logic [7:0]  cpu_din;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        mem_busy = 1'b1;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_err;

    cpu_mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_dout     (cpu_dout),
        .cpu_rdy      (cpu_rdy),
        .cpu_din      (cpu_din),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_busy     (mem_busy),
        .mem_rdata    (mem_rdata),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } strobe_t;

    typedef struct {
        logic [7:0] din;
        int         low;
    } done_t;

    strobe_t q_strobe[$];
    done_t   q_done[$];

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_din = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: strobes and ready-returns are matched against the queues.
    logic prev_rdy = 1'b1;
    int   low_cnt  = 0;

    always @(negedge clk) begin
        if (!reset) begin
            low_cnt  = 0;
            prev_rdy = 1'b1;
        end else begin
            if (mem_read_en || mem_write_en) begin
                strobe_t e;
                check("strobe_exclusive", {31'd0, mem_read_en && mem_write_en}, 32'd0);
                check("strobe_busy_low", {31'd0, mem_busy}, 32'd0);
                if (q_strobe.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = q_strobe.pop_front();
                    check("strobe_kind", {31'd0, mem_write_en}, {31'd0, e.wr});
                    check("strobe_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    check("strobe_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
                end
            end
            if (!cpu_rdy) begin
                low_cnt++;
            end else if (!prev_rdy) begin
                done_t d;
                if (q_done.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    d = q_done.pop_front();
                    check("ready_latency", low_cnt, d.low);
                    check("cpu_din", {24'd0, cpu_din}, {24'd0, d.din});
                end
                low_cnt = 0;
            end
            prev_rdy = cpu_rdy;
        end
    end

    // bist: ISSUE cycles with busy high; nbusy: busy-high cycles after strobe.
    task automatic do_access(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                             input int bist, input int nbusy, input logic [7:0] rd);
        strobe_t s;
        done_t   d;
        s.wr = ~rw;
        s.addr = addr;
        s.wdata = wd;
        q_strobe.push_back(s);
        if (rw) model_din = rd;
        d.din = model_din;
        d.low = bist + nbusy + 2;
        q_done.push_back(d);

        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_dout = wd;
        mem_busy = (bist > 0);
        tick();
        cpu_req = 1'b0; cpu_addr = ~addr; cpu_dout = ~wd; cpu_rw = ~rw;
        for (int i = 0; i < bist; i++) begin
            mem_busy = 1'b1;
            tick();
        end
        mem_busy = 1'b0;
        tick();
        mem_rdata = ~rd;
        for (int i = 0; i < nbusy; i++) begin
            mem_busy = 1'b1;
            tick();
        end
        mem_busy = 1'b0;
        mem_rdata = rd;
        tick();
        mem_rdata = ~rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        mem_busy = 1'b1;
        tick();
        tick();
        check("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        check("rst_cpu_din", {24'd0, cpu_din}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);

        // Controller BIST keeps busy high for 40 cycles after reset.
        reset = 1'b1;
        repeat (5) tick();
        do_access(1'b1, 16'h1234, 8'h00, 35, 1, 8'h3C);
        do_access(1'b1, 16'h0040, 8'h00, 0, 3, 8'hA5);
        do_access(1'b0, 16'hFFFC, 8'h55, 0, 2, 8'h00);
        check("wr_addr_stable", {16'd0, mem_addr}, 32'h0000FFFC);
        check("wr_wdata_stable", {24'd0, mem_wdata}, 32'h55);
        check("wr_din_kept", {24'd0, cpu_din}, 32'hA5);
        do_access(1'b0, 16'h8000, 8'hAA, 2, 5, 8'h00);
        do_access(1'b1, 16'h0001, 8'h00, 0, 6, 8'h7E);

        // Busy falls in the last counted WAIT cycle.
        do_access(1'b1, 16'h0BEE, 8'h11, 0, 7, 8'hC3);
        check("limit_no_err", {31'd0, mem_err}, 32'd0);
        check("limit_rdy", {31'd0, cpu_rdy}, 32'd1);

        // Reset during ISSUE with busy high.
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h4321; cpu_dout = 8'h99;
        mem_busy = 1'b1;
        tick();
        cpu_req = 1'b0;
        reset = 1'b0;
        tick();
        check("midrst_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("midrst_addr", {16'd0, mem_addr}, 32'd0);
        check("midrst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("midrst_din", {24'd0, cpu_din}, 32'd0);
        check("midrst_err", {31'd0, mem_err}, 32'd0);
        model_din = 8'h00;
        reset = 1'b1;
        mem_busy = 1'b0;
        repeat (4) tick();

        // Timeout: strobe at cycle 1, busy stuck high, ERROR from cycle 10.
        q_strobe.push_back('{wr: 1'b0, addr: 16'h2222, wdata: 8'h77});
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h2222; cpu_dout = 8'h77;
        tick();
        cpu_req = 1'b0;
        mem_busy = 1'b0;
        tick();
        mem_busy = 1'b1;
        repeat (7) tick();
        check("to_no_err_yet", {31'd0, mem_err}, 32'd0);
        tick();
        check("to_err", {31'd0, mem_err}, 32'd1);
        check("to_rdy_low", {31'd0, cpu_rdy}, 32'd0);
        mem_busy = 1'b0;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h3333; cpu_dout = 8'h44;
        tick();
        cpu_req = 1'b0;
        repeat (5) tick();
        check("to_err_sticky", {31'd0, mem_err}, 32'd1);
        check("to_rdy_stuck", {31'd0, cpu_rdy}, 32'd0);
        check("to_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("to_rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("to_rst_err", {31'd0, mem_err}, 32'd0);
        repeat (3) tick();

        check("strobe_queue_empty", q_strobe.size(), 32'd0);
        check("done_queue_empty", q_done.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
